// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, PSR flag bits
// and small opcode-classification helpers.
package alu_sequencer_pkg;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_CMP  = 5'd2,
      OP_AND  = 5'd3,
      OP_OR   = 5'd4,
      OP_XOR  = 5'd5,
      OP_NOT  = 5'd6,
      OP_LSH  = 5'd7,
      OP_RSH  = 5'd8,
      OP_ARSH = 5'd9
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB
   } state_e;

   // Bit positions inside alu_flags / psr, {N,Z,F,L,C}
   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_L = 1;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 4;

   function automatic logic op_legal(input logic [4:0] op);
      return op <= 5'(OP_ARSH);
   endfunction

   // CMP only produces flags; illegal opcodes produce nothing
   function automatic logic op_writes_reg(input logic [4:0] op);
      return op_legal(op) && (op != 5'(OP_CMP));
   endfunction

   function automatic logic op_updates_psr(input logic [4:0] op);
      return (op == 5'(OP_ADD)) || (op == 5'(OP_SUB)) || (op == 5'(OP_CMP));
   endfunction

   function automatic logic [15:0] ext_imm(input logic [7:0] imm, input logic sgn);
      return sgn ? {{8{imm[7]}}, imm} : {8'h00, imm};
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16x16 register file: one write port, two read paths latched on rd_en,
// and a combinational debug read port.
module alu_regfile
   import alu_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [15:0] wdata,
   input  logic        rd_en,
   input  logic [3:0]  raddr_a,
   input  logic [3:0]  raddr_b,
   output logic [15:0] rdata_a,
   output logic [15:0] rdata_b,
   input  logic [3:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   logic [15:0] regs [16];

   // Register storage with the single write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Operand read paths, held stable while the ALU works on them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else if (rd_en) begin
         rdata_a <= regs[raddr_a];
         rdata_b <= regs[raddr_b];
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer (IDLE/READ/EXEC/WB) that feeds an external
// ALU from the register file and retires results into registers and the PSR.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [4:0]  op_in,
   input  logic [3:0]  rdest_in,
   input  logic [3:0]  rsrc_in,
   input  logic [7:0]  imm_in,
   input  logic        imm_sel,
   input  logic        imm_signed,
   output logic [15:0] alu_rsrc,
   output logic [15:0] alu_rdest,
   output logic [4:0]  alu_op,
   input  logic [15:0] alu_out,
   input  logic [4:0]  alu_flags,
   output logic [4:0]  psr,
   output logic        done,
   output logic        err,
   input  logic [3:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   state_e      state;
   logic [4:0]  op_q;
   logic [3:0]  rdest_q;
   logic [3:0]  rsrc_q;
   logic [15:0] imm_q;
   logic        imm_sel_q;
   logic [15:0] result_q;
   logic [4:0]  flags_q;
   logic [15:0] opa;
   logic [15:0] opb_reg;
   logic        reg_we;

   assign reg_we = (state == S_WB) && op_writes_reg(op_q);

   alu_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (reg_we),
      .waddr    (rdest_q),
      .wdata    (result_q),
      .rd_en    (state == S_READ),
      .raddr_a  (rdest_q),
      .raddr_b  (rsrc_q),
      .rdata_a  (opa),
      .rdata_b  (opb_reg),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Sequencer FSM with registered handshake/status outputs and PSR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         instr_ready <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         op_q        <= '0;
         rdest_q     <= '0;
         rsrc_q      <= '0;
         imm_q       <= '0;
         imm_sel_q   <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         psr         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (instr_valid && instr_ready) begin
                  op_q        <= op_in;
                  rdest_q     <= rdest_in;
                  rsrc_q      <= rsrc_in;
                  imm_q       <= ext_imm(imm_in, imm_signed);
                  imm_sel_q   <= imm_sel;
                  instr_ready <= 1'b0;
                  state       <= S_READ;
               end
            end
            S_READ: state <= S_EXEC;
            S_EXEC: begin
               result_q <= alu_out;
               flags_q  <= alu_flags;
               done     <= 1'b1;
               err      <= !op_legal(op_q);
               state    <= S_WB;
            end
            S_WB: begin
               if (op_updates_psr(op_q)) psr <= flags_q;
               done        <= 1'b0;
               err         <= 1'b0;
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ALU drive: operands only during EXEC, CMP presented to the ALU as SUB
   always_comb begin
      alu_op    = '0;
      alu_rdest = '0;
      alu_rsrc  = '0;
      if (state == S_EXEC) begin
         alu_op    = (op_q == 5'(OP_CMP)) ? 5'(OP_SUB) : op_q;
         alu_rdest = opa;
         alu_rsrc  = imm_sel_q ? imm_q : opb_reg;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: provides a behavioural ALU, keeps a transaction-level
// model of registers/PSR checked every cycle, plus literal scenario checks.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [4:0]  op_in = '0;
   logic [3:0]  rdest_in = '0;
   logic [3:0]  rsrc_in = '0;
   logic [7:0]  imm_in = '0;
   logic        imm_sel = 1'b0;
   logic        imm_signed = 1'b0;
   logic [15:0] alu_rsrc, alu_rdest, alu_out, dbg_data;
   logic [4:0]  alu_op, alu_flags, psr;
   logic        done, err;
   logic [3:0]  dbg_addr = '0;

   int checks = 0;
   int errors = 0;

   alu_sequencer dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op_in(op_in), .rdest_in(rdest_in), .rsrc_in(rsrc_in), .imm_in(imm_in),
      .imm_sel(imm_sel), .imm_signed(imm_signed), .alu_rsrc(alu_rsrc),
      .alu_rdest(alu_rdest), .alu_op(alu_op), .alu_out(alu_out),
      .alu_flags(alu_flags), .psr(psr), .done(done), .err(err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {N,Z,F,L,C, result}
   function automatic logic [20:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic [4:0]  f;
      s = '0; r = '0; f = '0;
      case (op)
         5'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0];
            f[0] = s[16];
            f[2] = (a[15] == b[15]) && (r[15] != a[15]);
         end
         5'd1: begin
            r = a - b;
            f[1] = (a < b);
            f[0] = !(a < b);
            f[2] = (a < b) || ((a[15] != b[15]) && (r[15] != a[15]));
            f[4] = $signed(a) < $signed(b);
         end
         5'd3: r = a & b;
         5'd4: r = a | b;
         5'd5: r = a ^ b;
         5'd6: r = ~b;
         5'd7: r = a << b[3:0];
         5'd8: r = a >> b[3:0];
         5'd9: r = 16'($signed(a) >>> b[3:0]);
         default: r = '0;
      endcase
      if (op <= 5'd9) f[3] = (r == 16'h0);
      return {f, r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_model(alu_op, alu_rdest, alu_rsrc);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Transaction-level model: registers, PSR, and where the in-flight
   // instruction is (0 idle, 1..3 cycles after acceptance).
   logic [15:0] m_regs [16];
   logic [4:0]  m_psr;
   int          stage;
   logic [4:0]  m_op;
   logic [3:0]  m_rd;
   logic [15:0] m_a, m_b;

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_psr = '0; stage = 0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
   end

   always @(negedge clk) begin
      logic [20:0] res;
      logic [4:0]  eff;
      if (reset) begin
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_psr = '0;
         stage = 0;
         check("rst_done", 32'(done), 0);
         check("rst_err", 32'(err), 0);
         check("rst_psr", 32'(psr), 0);
      end else begin
         eff = (m_op == 5'd2) ? 5'd1 : m_op;
         check("ready", 32'(instr_ready), 32'(stage == 0));
         check("done", 32'(done), 32'(stage == 3));
         check("err", 32'(err), 32'(stage == 3 && m_op > 5'd9));
         check("alu_op", 32'(alu_op), (stage == 2) ? 32'(eff) : 0);
         check("alu_rdest", 32'(alu_rdest), (stage == 2) ? 32'(m_a) : 0);
         check("alu_rsrc", 32'(alu_rsrc), (stage == 2) ? 32'(m_b) : 0);
         check("psr", 32'(psr), 32'(m_psr));
         check("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
         case (stage)
            0: if (instr_valid) begin
                  m_op = op_in;
                  m_rd = rdest_in;
                  m_a  = m_regs[rdest_in];
                  m_b  = imm_sel ? (imm_signed ? {{8{imm_in[7]}}, imm_in} : {8'h00, imm_in})
                                 : m_regs[rsrc_in];
                  stage = 1;
               end
            3: begin
               res = alu_model(eff, m_a, m_b);
               if (m_op <= 5'd9 && m_op != 5'd2) m_regs[m_rd] = res[15:0];
               if (m_op <= 5'd2) m_psr = res[20:16];
               stage = 0;
            end
            default: stage = stage + 1;
         endcase
      end
   end

   // Issue one instruction and wait for it to retire; noise scrambles the
   // fields and keeps instr_valid high while the instruction is in flight.
   task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] imm, input logic sel, input logic sgn,
                        input logic noise, output logic err_seen, output logic [4:0] exec_op);
      int n;
      err_seen = 1'b0;
      exec_op  = '0;
      @(posedge clk); #1;
      op_in = op; rdest_in = rd; rsrc_in = rs; imm_in = imm;
      imm_sel = sel; imm_signed = sgn; instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!instr_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      if (noise) begin
         op_in = 5'($urandom); rdest_in = 4'($urandom); rsrc_in = 4'($urandom);
         imm_in = 8'($urandom); imm_sel = 1'($urandom); imm_signed = 1'($urandom);
      end else begin
         instr_valid = 1'b0;
      end
      n = 0;
      while (!done && n < 10) begin
         if (n == 1) exec_op = alu_op;
         @(posedge clk); #1; n++;
      end
      check("done_latency", 32'(n), 2);
      err_seen = err;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic rd_reg(input string name, input logic [3:0] idx, input logic [15:0] exp);
      dbg_addr = idx;
      #1;
      check(name, 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      logic       e;
      logic [4:0] xo;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Operand setup
      issue(5'd1, 4'd1, 4'd0, 8'h01, 1, 0, 0, e, xo);
      issue(5'd8, 4'd1, 4'd0, 8'h01, 1, 0, 0, e, xo);
      rd_reg("setup_r1", 4'd1, 16'h7FFF);
      issue(5'd0, 4'd2, 4'd0, 8'h01, 1, 0, 0, e, xo);
      issue(5'd0, 4'd3, 4'd0, 8'h03, 1, 0, 0, e, xo);
      issue(5'd0, 4'd4, 4'd0, 8'h05, 1, 0, 0, e, xo);
      issue(5'd0, 4'd5, 4'd0, 8'h05, 1, 0, 0, e, xo);
      issue(5'd0, 4'd6, 4'd0, 8'h01, 1, 0, 0, e, xo);
      issue(5'd7, 4'd6, 4'd0, 8'h0F, 1, 0, 0, e, xo);
      issue(5'd4, 4'd6, 4'd0, 8'h01, 1, 0, 0, e, xo);
      rd_reg("setup_r6", 4'd6, 16'h8001);
      issue(5'd0, 4'd7, 4'd0, 8'h10, 1, 0, 0, e, xo);

      // Overflowing ADD, with instr_valid held and fields scrambled in flight
      issue(5'd0, 4'd1, 4'd2, 8'h00, 0, 0, 1, e, xo);
      rd_reg("add_r1", 4'd1, 16'h8000);
      check("add_psr", 32'(psr), 32'h04);
      check("add_err", 32'(e), 0);

      // CMP: driven as SUB, no write
      issue(5'd2, 4'd3, 4'd4, 8'h00, 0, 0, 0, e, xo);
      check("cmp_alu_op", 32'(xo), 1);
      rd_reg("cmp_r3", 4'd3, 16'h0003);
      check("cmp_psr", 32'(psr), 32'h16);

      // SUB immediate to zero
      issue(5'd1, 4'd5, 4'd0, 8'h05, 1, 0, 0, e, xo);
      rd_reg("sub_r5", 4'd5, 16'h0000);
      check("sub_psr", 32'(psr), 32'h09);

      // LSH with rdest == rsrc, PSR untouched
      issue(5'd7, 4'd6, 4'd6, 8'h00, 0, 0, 0, e, xo);
      rd_reg("lsh_r6", 4'd6, 16'h0002);
      check("lsh_psr", 32'(psr), 32'h09);

      // Illegal opcode
      issue(5'd10, 4'd6, 4'd1, 8'h00, 0, 0, 0, e, xo);
      check("ill_err", 32'(e), 1);
      rd_reg("ill_r6", 4'd6, 16'h0002);
      rd_reg("ill_r1", 4'd1, 16'h8000);
      check("ill_psr", 32'(psr), 32'h09);

      // Immediate extension
      issue(5'd0, 4'd7, 4'd0, 8'hFF, 1, 1, 0, e, xo);
      rd_reg("sext_r7", 4'd7, 16'h000F);
      check("sext_c", 32'(psr[FLAG_C]), 1);
      issue(5'd0, 4'd7, 4'd0, 8'h01, 1, 0, 0, e, xo);
      issue(5'd0, 4'd7, 4'd0, 8'hFF, 1, 0, 0, e, xo);
      rd_reg("zext_r7", 4'd7, 16'h010F);

      // Every register writable
      for (int i = 0; i < 16; i++) begin
         issue(5'd5, 4'(i), 4'(i), 8'h00, 0, 0, 0, e, xo);
         issue(5'd0, 4'(i), 4'd0, 8'(i * 7 + 3), 1, 0, 0, e, xo);
         rd_reg("all_regs", 4'(i), 16'(i * 7 + 3));
      end
      issue(5'd2, 4'd0, 4'd1, 8'h00, 0, 0, 0, e, xo);
      check("cmp2_psr", 32'(psr), 32'h16);

      // Reset during EXEC of an ADD abandons it
      @(posedge clk); #1;
      op_in = 5'd0; rdest_in = 4'd2; imm_in = 8'h01; imm_sel = 1'b1; imm_signed = 1'b0;
      instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("post_rst_ready", 32'(instr_ready), 1);
      repeat (5) @(posedge clk);
      #1;
      rd_reg("rst_r2", 4'd2, 16'h0000);
      rd_reg("rst_r9", 4'd9, 16'h0000);
      check("rst_psr_final", 32'(psr), 0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 instr_valid  input  1  instruction fields below are valid this cycle.
REQ-004 instr_ready  output  1  sequencer can accept an instruction (high only in IDLE).
REQ-005 op_in  input  5  ALU opcode: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOT=6, LSH=7, RSH=8, ARSH=9; 10-31 illegal.
REQ-006 rdest_in  input  4  destination/first-operand register index.
REQ-007 rsrc_in  input  4  source register index (used when imm_sel=0).
REQ-008 imm_in  input  8  immediate source operand (used when imm_sel=1).
REQ-009 imm_sel  input  1  1 selects the extended immediate as Rsrc operand.
REQ-010 imm_signed  input  1  1 sign-extends imm_in, 0 zero-extends.
REQ-011 alu_rsrc  output  16  operand driven to the ALU Rsrc port.
REQ-012 alu_rdest  output  16  operand driven to the ALU Rdest port.
REQ-013 alu_op  output  5  opcode driven to the ALU.
REQ-014 alu_out  input  16  ALU result.
REQ-015 alu_flags  input  5  ALU flags {N,Z,F,L,C} (bit4..bit0).
REQ-016 psr  output  5  processor status register, same bit order as alu_flags.
REQ-017 done  output  1  one-cycle pulse when an accepted instruction retires.
REQ-018 err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.
REQ-019 dbg_addr  input  4  register-file debug read index.
REQ-020 dbg_data  output  16  combinational read of register dbg_addr.

Function
REQ-021 The FSM SHALL have states IDLE, READ, EXEC, WB; IDLE->READ on instr_valid&&instr_ready, READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-022 On acceptance the sequencer SHALL latch all instruction fields; instr_valid outside IDLE SHALL be ignored.
REQ-023 In READ the sequencer SHALL latch operand A = R[rdest] and operand B = imm_sel ? ext(imm_in) : R[rsrc].
REQ-024 In EXEC alu_rdest=A, alu_rsrc=B, alu_op=latched op, except CMP SHALL be driven as SUB (alu_op=1); on the EXEC->WB edge alu_out and alu_flags SHALL be captured.
REQ-025 alu_op, alu_rsrc, alu_rdest SHALL be 0 outside EXEC.
REQ-026 In WB, for ADD/SUB/AND/OR/XOR/NOT/LSH/RSH/ARSH, R[rdest] SHALL be written with the captured result at the WB->IDLE edge.
REQ-027 CMP SHALL NOT write the register file.
REQ-028 psr SHALL be loaded with captured flags at the WB->IDLE edge for ADD, SUB, CMP only; all other ops SHALL leave psr unchanged.
REQ-029 Illegal opcode: no register write, no psr update, err=1 in WB.
REQ-030 done SHALL be high exactly in WB, i.e. acceptance edge + 3 cycles; next acceptance no earlier than the cycle after WB (4-cycle throughput).
REQ-031 rdest==rsrc SHALL read the same value for both operands; result written back to that register.
REQ-032 All 16 registers SHALL be writable; dbg_data SHALL reflect a WB write from the cycle after the write edge.

Reset
REQ-033 reset SHALL asynchronously force state=IDLE, all 16 registers=0, psr=0, done=0, err=0, latched fields=0.
REQ-034 reset asserted mid-instruction SHALL abandon it: no register write, no psr update, no done pulse.
REQ-035 After reset deassertion instr_ready SHALL be 1 in the first clock cycle.

Structure
REQ-036 A shared package SHALL hold opcode constants, FSM state encoding, and flag bit indices (C=0, L=1, F=2, Z=3, N=4).
REQ-037 The 16x16 register file (one write port, two sync-latched read paths plus one combinational debug port) SHALL be sub-module alu_regfile.
REQ-038 The ALU SHALL be instantiated outside alu_sequencer and connected via alu_* ports.

Verification
REQ-039 R1=0x7FFF, R2=0x0001, ADD rdest=1 rsrc=2 -> done at accept+3, R1=0x8000, psr=5'b00100.
REQ-040 R5=0x0005, SUB rdest=5 imm_sel=1 imm_in=0x05 -> R5=0x0000, psr=5'b01001.
REQ-041 R3=0x0003, R4=0x0005, CMP rdest=3 rsrc=4 -> alu_op=1 in EXEC, R3 still 0x0003, psr=5'b10110.
REQ-042 psr=5'b01001, R6=0x8001, LSH rdest=6 rsrc=6 -> R6=0x0002, psr stays 5'b01001.
REQ-043 R7=0x0010, ADD rdest=7 imm_sel=1 imm_signed=1 imm_in=0xFF -> R7=0x000F, psr C bit=1; imm_signed=0 -> R7=0x010F.
REQ-044 op_in=0x0A -> err and done high at accept+3, no state change; separately reset asserted in EXEC of ADD -> target register 0, psr 0, no done.
